// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file access path.
package regfile_pkg;

  localparam int unsigned RF_WIDTH  = 64;
  localparam int unsigned RF_DEPTH  = 16;
  localparam int unsigned RF_SELECT = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic                 we;
    logic [RF_SELECT-1:0] addr_a;
    logic [RF_SELECT-1:0] addr_b;
    logic [RF_WIDTH-1:0]  wdata;
  } op_t;

endpackage

// File: rtl/regfile_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request after 'last'.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            any,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  win_idx
);

  logic [IDW-1:0] cand;
  logic           found;

  // Walk last+1 .. last+NREQ (wrapping on IDW bits); the first hit wins.
  always_comb begin
    any     = |req;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = last + IDW'(k);
      if (!found && req[cand]) begin
        found     = 1'b1;
        win[cand] = 1'b1;
        win_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin access controller sharing one register file among NREQ requesters.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = RF_WIDTH,
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned SELECT = RF_SELECT,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned IDW    = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*SELECT-1:0] req_addr_a,
  input  logic [NREQ*SELECT-1:0] req_addr_b,
  input  logic [NREQ*WIDTH-1:0]  req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_we,
  output logic [WIDTH-1:0]       rsp_data_a,
  output logic [WIDTH-1:0]       rsp_data_b,
  output logic                   rf_cs,
  output logic                   rf_re,
  output logic                   rf_we,
  output logic [SELECT-1:0]      rf_read_reg1,
  output logic [SELECT-1:0]      rf_read_reg2,
  output logic [SELECT-1:0]      rf_write_register,
  output logic [WIDTH-1:0]       rf_write_data,
  input  logic [WIDTH-1:0]       rf_read_data1,
  input  logic [WIDTH-1:0]       rf_read_data2
);

  // Reject parameter sets where the address cannot reach every register
  // or the id field cannot name every requester.
  if (DEPTH > (1 << SELECT)) begin : g_select_too_narrow
    $error("regfile_arbiter: SELECT too narrow for DEPTH");
  end
  if (NREQ != (1 << IDW)) begin : g_idw_mismatch
    $error("regfile_arbiter: NREQ must equal 2**IDW");
  end

  state_e         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] cur_id;
  logic           cur_we;

  logic            pick_any;
  logic [NREQ-1:0] pick_win;
  logic [IDW-1:0]  pick_idx;

  logic              sel_we;
  logic [SELECT-1:0] sel_addr_a;
  logic [SELECT-1:0] sel_addr_b;
  logic [WIDTH-1:0]  sel_wdata;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req     (req),
    .last    (last),
    .any     (pick_any),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

  // Op fields of the current round-robin candidate.
  assign sel_we     = req_we[pick_idx];
  assign sel_addr_a = req_addr_a[32'(pick_idx) * SELECT +: SELECT];
  assign sel_addr_b = req_addr_b[32'(pick_idx) * SELECT +: SELECT];
  assign sel_wdata  = req_wdata[32'(pick_idx) * WIDTH +: WIDTH];

  // IDLE picks a winner and launches its access; ACCESS returns the response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      last              <= IDW'(NREQ - 1);
      cur_id            <= '0;
      cur_we            <= 1'b0;
      gnt               <= '0;
      rsp_valid         <= 1'b0;
      rsp_id            <= '0;
      rsp_we            <= 1'b0;
      rsp_data_a        <= '0;
      rsp_data_b        <= '0;
      rf_cs             <= 1'b0;
      rf_re             <= 1'b0;
      rf_we             <= 1'b0;
      rf_read_reg1      <= '0;
      rf_read_reg2      <= '0;
      rf_write_register <= '0;
      rf_write_data     <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rf_cs     <= 1'b0;
      rf_re     <= 1'b0;
      rf_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state  <= ACCESS;
            last   <= pick_idx;
            cur_id <= pick_idx;
            cur_we <= sel_we;
            gnt    <= pick_win;
            rf_cs  <= 1'b1;
            if (sel_we) begin
              rf_we             <= 1'b1;
              rf_write_register <= sel_addr_a;
              rf_write_data     <= sel_wdata;
            end else begin
              rf_re        <= 1'b1;
              rf_read_reg1 <= sel_addr_a;
              rf_read_reg2 <= sel_addr_b;
            end
          end
        end
        ACCESS: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_id    <= cur_id;
          rsp_we    <= cur_we;
          if (cur_we) begin
            rsp_data_a <= '0;
            rsp_data_b <= '0;
          end else begin
            rsp_data_a <= rf_read_data1;
            rsp_data_b <= rf_read_data2;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a behavioural register file.
module tb_regfile_arbiter;

  localparam int unsigned W  = 64;
  localparam int unsigned S  = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned ID = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      req_we = '0;
  logic [N*S-1:0]    req_addr_a = '0;
  logic [N*S-1:0]    req_addr_b = '0;
  logic [N*W-1:0]    req_wdata = '0;
  logic [N-1:0]      gnt;
  logic              rsp_valid;
  logic [ID-1:0]     rsp_id;
  logic              rsp_we;
  logic [W-1:0]      rsp_data_a;
  logic [W-1:0]      rsp_data_b;
  logic              rf_cs, rf_re, rf_we;
  logic [S-1:0]      rf_read_reg1, rf_read_reg2, rf_write_register;
  logic [W-1:0]      rf_write_data;
  logic [W-1:0]      rf_read_data1, rf_read_data2;

  typedef struct {
    logic [ID-1:0] id;
    logic          we;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [W-1:0] rf_mem [16];
  logic [W-1:0] ref_mem[16];

  regfile_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .req               (req),
    .req_we            (req_we),
    .req_addr_a        (req_addr_a),
    .req_addr_b        (req_addr_b),
    .req_wdata         (req_wdata),
    .gnt               (gnt),
    .rsp_valid         (rsp_valid),
    .rsp_id            (rsp_id),
    .rsp_we            (rsp_we),
    .rsp_data_a        (rsp_data_a),
    .rsp_data_b        (rsp_data_b),
    .rf_cs             (rf_cs),
    .rf_re             (rf_re),
    .rf_we             (rf_we),
    .rf_read_reg1      (rf_read_reg1),
    .rf_read_reg2      (rf_read_reg2),
    .rf_write_register (rf_write_register),
    .rf_write_data     (rf_write_data),
    .rf_read_data1     (rf_read_data1),
    .rf_read_data2     (rf_read_data2)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] init_val(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  // Register file: combinational read, write on the clock edge ending the access.
  assign rf_read_data1 = rf_mem[rf_read_reg1];
  assign rf_read_data2 = rf_mem[rf_read_reg2];
  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = init_val(i);
    forever begin
      @(posedge clock);
      if (rf_cs && rf_we) rf_mem[rf_write_register] <= rf_write_data;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  // Monitor: protocol rules every cycle, responses popped from the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      check("rf_re_we_exclusive", 64'(rf_re & rf_we), 64'(0));
      check("rf_cs_only_with_gnt", 64'(rf_cs), 64'(gnt != '0));
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stray_rsp actual id=%0d we=%0d required no response", rsp_id, rsp_we);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_we", 64'(rsp_we), 64'(e.we));
        check("rsp_data_a", rsp_data_a, e.a);
        check("rsp_data_b", rsp_data_b, e.b);
      end
    end
  end

  task automatic set_fields(input int id, input logic we, input logic [S-1:0] a,
                            input logic [S-1:0] b, input logic [W-1:0] wd);
    req_we[id]              = we;
    req_addr_a[id*S +: S]   = a;
    req_addr_b[id*S +: S]   = b;
    req_wdata[id*W +: W]    = wd;
  endtask

  task automatic push_exp(input int id, input logic we, input logic [S-1:0] a,
                          input logic [S-1:0] b, input logic [W-1:0] wd);
    exp_t e;
    e.id = ID'(id);
    e.we = we;
    if (we) begin
      e.a = '0;
      e.b = '0;
      ref_mem[a] = wd;
    end else begin
      e.a = ref_mem[a];
      e.b = ref_mem[b];
    end
    exp_q.push_back(e);
  endtask

  // Returns at the negedge of the cycle in which gnt[id] is seen, bounded.
  task automatic wait_gnt(input int id, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2 * N + 2 && !ok; n++) begin
      @(negedge clock);
      if (gnt[id]) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout id=%0d actual=none required=grant", id);
    end else begin
      check("gnt_onehot", 64'(gnt), 64'(1) << id);
    end
  endtask

  task automatic do_op(input int id, input logic we, input logic [S-1:0] a,
                       input logic [S-1:0] b, input logic [W-1:0] wd);
    bit ok;
    @(negedge clock);
    set_fields(id, we, a, b, wd);
    push_exp(id, we, a, b, wd);
    req[id] = 1'b1;
    wait_gnt(id, ok);
    req[id] = 1'b0;
  endtask

  initial begin
    bit           ok;
    logic [N-1:0] eg;
    logic         seen;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

    // Reset values
    #2;
    check("reset_gnt", 64'(gnt), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_id_we", 64'({rsp_id, rsp_we}), 64'(0));
    check("reset_rsp_data_a", rsp_data_a, 64'(0));
    check("reset_rsp_data_b", rsp_data_b, 64'(0));
    check("reset_rf_ctrl", 64'({rf_cs, rf_re, rf_we}), 64'(0));
    check("reset_rf_addr", 64'({rf_read_reg1, rf_read_reg2, rf_write_register}), 64'(0));
    check("reset_rf_wdata", rf_write_data, 64'(0));
    @(negedge clock);
    reset = 1'b1;

    // All four requesters reading: grants rotate 0,1,2,3,0 every second cycle
    @(negedge clock);
    for (int i = 0; i < 4; i++) set_fields(i, 1'b0, S'(i), S'(i + 4), '0);
    for (int k = 0; k < 5; k++) push_exp(k % 4, 1'b0, S'(k % 4), S'((k % 4) + 4), '0);
    req = 4'b1111;
    for (int j = 0; j < 9; j++) begin
      @(negedge clock);
      eg = (j % 2 == 0) ? 4'(1 << ((j / 2) % 4)) : 4'b0000;
      check("rr_gnt_seq", 64'(gnt), 64'(eg));
      if (j == 8) req = '0;
    end

    // Write then read-back through another requester, with response timing
    do_op(2, 1'b1, 4'd5, 4'd0, 64'h0000_0000_DEAD_BEEF);
    @(negedge clock);
    set_fields(1, 1'b0, 4'd5, 4'd0, '0);
    push_exp(1, 1'b0, 4'd5, 4'd0, '0);
    req[1] = 1'b1;
    wait_gnt(1, ok);
    req[1] = 1'b0;
    @(negedge clock);
    check("raw_rsp_valid_timing", 64'(rsp_valid), 64'(1));
    check("raw_rsp_id", 64'(rsp_id), 64'(1));
    check("raw_rsp_data_a", rsp_data_a, 64'h0000_0000_DEAD_BEEF);

    // Single requester held high: grant every second cycle, 8 responses
    set_fields(3, 1'b0, 4'd5, 4'd7, '0);
    for (int k = 0; k < 8; k++) push_exp(3, 1'b0, 4'd5, 4'd7, '0);
    req = 4'b1000;
    for (int j = 0; j < 16; j++) begin
      @(negedge clock);
      eg = (j % 2 == 0) ? 4'b1000 : 4'b0000;
      check("single_gnt_seq", 64'(gnt), 64'(eg));
      if (j == 14) req = '0;
    end

    // Requester 3 withdraws while requester 1 is granted
    @(negedge clock);
    set_fields(1, 1'b0, 4'd2, 4'd9, '0);
    set_fields(3, 1'b1, 4'd4, 4'd0, 64'h1234_5678_9ABC_DEF0);
    push_exp(1, 1'b0, 4'd2, 4'd9, '0);
    req = 4'b1010;
    @(negedge clock);
    check("drop_gnt1", 64'(gnt), 64'(4'b0010));
    req = '0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (gnt != '0) seen = 1'b1;
    end
    check("drop_no_more_gnt", 64'(seen), 64'(0));
    do_op(0, 1'b0, 4'd4, 4'd2, '0);

    // Random ops against the register content model
    for (int k = 0; k < 200; k++) begin
      do_op(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            {$urandom, $urandom});
    end

    // Reset during ACCESS: outputs drop at once, op dropped, requester 0 first
    @(negedge clock);
    @(negedge clock);
    set_fields(1, 1'b0, 4'd1, 4'd2, '0);
    req = 4'b0010;
    wait_gnt(1, ok);
    #1;
    reset = 1'b0;
    req = '0;
    #1;
    check("midreset_gnt", 64'(gnt), 64'(0));
    check("midreset_rf_cs", 64'(rf_cs), 64'(0));
    check("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = rf_mem[i];
    @(negedge clock);
    for (int i = 0; i < 4; i++) set_fields(i, 1'b0, S'(i + 6), S'(i), '0);
    push_exp(0, 1'b0, 4'd6, 4'd0, '0);
    req = 4'b1111;
    @(negedge clock);
    check("post_reset_first_gnt", 64'(gnt), 64'(4'b0001));
    req = '0;

    repeat (6) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
